// File: rtl/kick_anim_ctrl.sv
// kick_anim_ctrl: kick sprite animation sequencer.
// Steps frames on vsync ticks, drives ROM base, flags hit frame.
module kick_anim_ctrl #(
  parameter int NUM_FRAMES      = 4,
  parameter int TICKS_PER_FRAME = 6,
  parameter int COOLDOWN_TICKS  = 10,
  parameter int HIT_FRAME       = 2,
  parameter int FRAME_PIXELS    = 6144,
  parameter int ADDR_W          = 15
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              kick_req,
  input  logic              hit_stun,
  output logic              anim_active,
  output logic              busy,
  output logic [2:0]        frame_idx,
  output logic [ADDR_W-1:0] frame_base,
  output logic              hit_window,
  output logic              done,
  output logic              aborted
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    RECOVER
  } state_t;

  localparam logic [2:0] LAST_F = 3'(NUM_FRAMES - 1);
  localparam logic [5:0] LAST_T = 6'(TICKS_PER_FRAME - 1);
  localparam logic [7:0] CD_LD  = 8'(COOLDOWN_TICKS);
  localparam logic [2:0] HIT_F  = 3'(HIT_FRAME);

  state_t            state;
  state_t            state_n;
  logic [5:0]        tick_cnt;
  logic [5:0]        tick_n;
  logic [7:0]        cool;
  logic [7:0]        cool_n;
  logic [2:0]        idx_n;
  logic [ADDR_W-1:0] base_n;
  logic              anim_n;
  logic              busy_n;
  logic              hit_n;
  logic              done_n;
  logic              abort_n;

  // State, counters and every output are registered here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      cool        <= '0;
      anim_active <= 1'b0;
      busy        <= 1'b0;
      frame_idx   <= '0;
      frame_base  <= '0;
      hit_window  <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      cool        <= cool_n;
      anim_active <= anim_n;
      busy        <= busy_n;
      frame_idx   <= idx_n;
      frame_base  <= base_n;
      hit_window  <= hit_n;
      done        <= done_n;
      aborted     <= abort_n;
    end
  end

  // Next state and next outputs; stun aborts any active phase.
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    cool_n  = cool;
    idx_n   = frame_idx;
    anim_n  = anim_active;
    busy_n  = busy;
    done_n  = 1'b0;
    abort_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (kick_req && !hit_stun) begin
          state_n = PLAY;
          tick_n  = '0;
          idx_n   = '0;
          anim_n  = 1'b1;
          busy_n  = 1'b1;
        end
      end
      PLAY: begin
        if (hit_stun) begin
          state_n = IDLE;
          tick_n  = '0;
          cool_n  = '0;
          idx_n   = '0;
          anim_n  = 1'b0;
          busy_n  = 1'b0;
          abort_n = 1'b1;
        end else if (frame_tick) begin
          if (tick_cnt == LAST_T) begin
            tick_n = '0;
            if (frame_idx == LAST_F) begin
              state_n = RECOVER;
              done_n  = 1'b1;
              anim_n  = 1'b0;
              idx_n   = '0;
              cool_n  = CD_LD;
            end else begin
              idx_n = frame_idx + 3'd1;
            end
          end else begin
            tick_n = tick_cnt + 6'd1;
          end
        end
      end
      RECOVER: begin
        if (hit_stun) begin
          state_n = IDLE;
          tick_n  = '0;
          cool_n  = '0;
          idx_n   = '0;
          anim_n  = 1'b0;
          busy_n  = 1'b0;
          abort_n = 1'b1;
        end else if (cool == 8'd0) begin
          state_n = IDLE;
          busy_n  = 1'b0;
        end else if (frame_tick) begin
          if (cool == 8'd1) begin
            state_n = IDLE;
            cool_n  = '0;
            busy_n  = 1'b0;
          end else begin
            cool_n = cool - 8'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
        cool_n  = '0;
        idx_n   = '0;
        anim_n  = 1'b0;
        busy_n  = 1'b0;
      end
    endcase
    base_n = ADDR_W'(32'(idx_n) * 32'(FRAME_PIXELS));
    hit_n  = (state_n == PLAY) && (idx_n == HIT_F);
  end

endmodule

// File: tb/tb_kick_anim_ctrl.sv
// tb_kick_anim_ctrl: scoreboard bench for kick_anim_ctrl.
// Two instances: default timing and 1-tick/no-cooldown timing.
module tb_kick_anim_ctrl;

  logic        clk;
  logic        rst;
  logic        k0, t0, s0;
  logic        k1, t1, s1;
  logic        an0, bz0, hw0, dn0, ab0;
  logic        an1, bz1, hw1, dn1, ab1;
  logic [2:0]  fi0, fi1;
  logic [14:0] fb0, fb1;
  logic [22:0] o0, o1;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    int          dut;
    string       tag;
    logic [22:0] v;
  } exp_t;

  exp_t sbq[$];

  kick_anim_ctrl u_d0 (
    .Clk(clk), .Reset(rst), .frame_tick(t0),
    .kick_req(k0), .hit_stun(s0),
    .anim_active(an0), .busy(bz0),
    .frame_idx(fi0), .frame_base(fb0),
    .hit_window(hw0), .done(dn0), .aborted(ab0)
  );

  kick_anim_ctrl #(
    .TICKS_PER_FRAME(1),
    .COOLDOWN_TICKS(0)
  ) u_d1 (
    .Clk(clk), .Reset(rst), .frame_tick(t1),
    .kick_req(k1), .hit_stun(s1),
    .anim_active(an1), .busy(bz1),
    .frame_idx(fi1), .frame_base(fb1),
    .hit_window(hw1), .done(dn1), .aborted(ab1)
  );

  assign o0 = {an0, bz0, fi0, fb0, hw0, dn0, ab0};
  assign o1 = {an1, bz1, fi1, fb1, hw1, dn1, ab1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] pk(
    logic a, logic b, logic [2:0] i,
    logic [14:0] fb, logic h, logic d, logic x);
    return {a, b, i, fb, h, d, x};
  endfunction

  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    #1;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk(e.tag, {9'd0, (e.dut != 0) ? o1 : o0}, {9'd0, e.v});
    end
  end

  task automatic drv(int d, logic r, logic k, logic t, logic s);
    @(negedge clk);
    rst = r;
    k0 = (d == 0) ? k : 1'b0;
    t0 = (d == 0) ? t : 1'b0;
    s0 = (d == 0) ? s : 1'b0;
    k1 = (d == 1) ? k : 1'b0;
    t1 = (d == 1) ? t : 1'b0;
    s1 = (d == 1) ? s : 1'b0;
  endtask

  task automatic push(int d, string tag, logic [22:0] v);
    exp_t e;
    e.due = cyc + 1;
    e.dut = d;
    e.tag = tag;
    e.v   = v;
    sbq.push_back(e);
  endtask

  task automatic ticks(int d, int n, logic k);
    repeat (n) begin
      drv(d, 1'b0, k, 1'b1, 1'b0);
      drv(d, 1'b0, k, 1'b0, 1'b0);
    end
  endtask

  logic [22:0] zero, st0, f1, f2, f3, dnv, abv, rcv;

  initial begin
    zero = pk(0, 0, 3'd0, 15'd0, 0, 0, 0);
    st0  = pk(1, 1, 3'd0, 15'd0, 0, 0, 0);
    f1   = pk(1, 1, 3'd1, 15'd6144, 0, 0, 0);
    f2   = pk(1, 1, 3'd2, 15'd12288, 1, 0, 0);
    f3   = pk(1, 1, 3'd3, 15'd18432, 0, 0, 0);
    dnv  = pk(0, 1, 3'd0, 15'd0, 0, 1, 0);
    rcv  = pk(0, 1, 3'd0, 15'd0, 0, 0, 0);
    abv  = pk(0, 0, 3'd0, 15'd0, 0, 0, 1);
    rst = 1'b1;
    {k0, t0, s0, k1, t1, s1} = '0;

    drv(0, 1, 0, 0, 0);
    drv(0, 1, 0, 0, 0);
    push(0, "rst", zero);
    push(1, "d1_rst", zero);
    drv(0, 0, 0, 0, 0);
    push(0, "rst_rel", zero);

    drv(0, 0, 1, 0, 0); push(0, "start", st0);
    drv(0, 0, 0, 0, 0); push(0, "start_hold", st0);
    ticks(0, 5, 0);
    drv(0, 0, 0, 0, 0); push(0, "t5", st0);
    ticks(0, 1, 0);
    drv(0, 0, 0, 0, 0); push(0, "t6", f1);
    ticks(0, 6, 0);
    drv(0, 0, 0, 0, 0); push(0, "t12", f2);
    ticks(0, 6, 0);
    drv(0, 0, 0, 0, 0); push(0, "t18", f3);
    ticks(0, 5, 0);
    drv(0, 0, 1, 1, 0); push(0, "t24_done", dnv);
    drv(0, 0, 1, 0, 0); push(0, "done_1cyc", rcv);
    ticks(0, 9, 1);
    drv(0, 0, 1, 0, 0); push(0, "cd9", rcv);
    drv(0, 0, 1, 1, 0); push(0, "cd10", zero);
    drv(0, 0, 1, 0, 0); push(0, "restart", st0);
    drv(0, 0, 0, 0, 0);

    ticks(0, 15, 0);
    drv(0, 0, 0, 0, 0); push(0, "pre_stun", f2);
    drv(0, 0, 0, 0, 1); push(0, "stun", abv);
    drv(0, 0, 1, 0, 0); push(0, "stun_restart", st0);
    drv(0, 0, 0, 0, 1); push(0, "stun2", abv);
    drv(0, 0, 0, 0, 0); push(0, "stun2_idle", zero);

    drv(0, 0, 1, 1, 0); push(0, "kick_tick", st0);
    ticks(0, 5, 0);
    drv(0, 0, 0, 0, 0); push(0, "kt5", st0);
    ticks(0, 1, 0);
    drv(0, 0, 0, 0, 0); push(0, "kt6", f1);
    drv(0, 0, 0, 0, 1); push(0, "stun3", abv);
    drv(0, 0, 1, 0, 1); push(0, "kick_stun", zero);
    drv(0, 0, 0, 0, 0); push(0, "kick_stun_hold", zero);

    drv(0, 0, 1, 0, 0); push(0, "start_f", st0);
    ticks(0, 23, 0);
    drv(0, 0, 0, 1, 1); push(0, "stun_final", abv);
    drv(0, 0, 0, 0, 0); push(0, "stun_final_idle", zero);

    drv(0, 0, 1, 0, 0);
    ticks(0, 23, 0);
    drv(0, 0, 0, 1, 0); push(0, "done_r", dnv);
    drv(0, 0, 0, 0, 1); push(0, "stun_rec", abv);
    drv(0, 0, 0, 0, 0);

    drv(0, 0, 1, 0, 0);
    ticks(0, 6, 0);
    drv(0, 0, 0, 0, 0); push(0, "pre_rst", f1);
    drv(0, 1, 0, 0, 0); push(0, "rst_mid", zero);
    drv(0, 0, 0, 0, 0); push(0, "rst_mid_rel", zero);

    drv(1, 0, 1, 0, 0); push(1, "d1_start", st0);
    drv(1, 0, 0, 1, 0); push(1, "d1_f1", f1);
    drv(1, 0, 0, 1, 0); push(1, "d1_f2", f2);
    drv(1, 0, 0, 1, 0); push(1, "d1_f3", f3);
    drv(1, 0, 1, 1, 0); push(1, "d1_done", dnv);
    drv(1, 0, 1, 0, 0); push(1, "d1_rec1", zero);
    drv(1, 0, 1, 0, 0); push(1, "d1_restart", st0);
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0);

    chk("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/kick_anim_ctrl.md
Name: kick_anim_ctrl

Overview:
Sequencer for a fighter's kick sprite animation. On a kick request it steps the sprite frame index on vertical-sync ticks and drives the frame base address into the sprite ROM, whose 4-bit pixel indices feed the kick palette lookup. It also flags the damage-active frame to collision logic, enforces a recovery cooldown and lets a hit-stun abort the move. It sits between the player input FSM and the sprite ROM/palette datapath.

Parameters:
NUM_FRAMES, 4, number of animation frames (2..8)
TICKS_PER_FRAME, 6, frame_tick pulses each frame is held (1..63)
COOLDOWN_TICKS, 10, frame_tick pulses in recovery before a new kick is accepted (0..255)
HIT_FRAME, 2, frame index during which hit_window is asserted
FRAME_PIXELS, 6144, ROM words per frame (64x96 sprite)
ADDR_W, 15, sprite ROM address width

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
frame_tick  in  1  single-cycle pulse per video frame (vsync)
kick_req  in  1  kick request, sampled every cycle
hit_stun  in  1  abort request from collision/damage logic
anim_active  out  1  high while frames are playing
busy  out  1  high in PLAY or RECOVER
frame_idx  out  3  current frame number
frame_base  out  ADDR_W  frame_idx*FRAME_PIXELS, sprite ROM base address
hit_window  out  1  damage-active flag
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse on hit_stun abort

Behaviour:
- States: IDLE, PLAY, RECOVER. All outputs are registered.
- Reset (synchronous, priority over everything): state IDLE, every output 0, tick counter 0, cooldown counter 0.
- IDLE:
  - kick_req=1 and hit_stun=0 -> PLAY next cycle; frame_idx=0, frame_base=0, tick_cnt=0, anim_active=1.
  - A frame_tick in the same cycle as the start is not counted.
  - kick_req=1 with hit_stun=1 -> stay IDLE; stun blocks the start.
- PLAY:
  - Each frame_tick increments tick_cnt.
  - When frame_tick arrives with tick_cnt==TICKS_PER_FRAME-1: tick_cnt->0 and frame_idx increments. frame_base updates in the same cycle, so frame_base always equals frame_idx*FRAME_PIXELS.
  - When that happens on frame NUM_FRAMES-1: go to RECOVER, pulse done for 1 cycle, anim_active->0, frame_idx->0, frame_base->0.
- Frame hold time: each frame is held for exactly TICKS_PER_FRAME frame_ticks. Total play time is NUM_FRAMES*TICKS_PER_FRAME ticks.
- hit_window = (state==PLAY && frame_idx==HIT_FRAME), registered and aligned with frame_idx.
- RECOVER:
  - Cooldown counter loads COOLDOWN_TICKS on entry and decrements on each frame_tick.
  - When a frame_tick arrives with the counter at 1, go to IDLE.
  - COOLDOWN_TICKS=0: RECOVER lasts exactly 1 cycle, then IDLE.
- kick_req outside IDLE is ignored. No queuing; it must be (re)held in IDLE to start.
- hit_stun=1 in PLAY or RECOVER -> IDLE next cycle. All outputs go to 0 with aborted pulsed for 1 cycle. No done pulse, no cooldown.
- Same-cycle collisions:
  - hit_stun beats the final frame advance: aborted fires, done does not.
  - In IDLE, hit_stun is ignored.
- Counter widths:
  - tick_cnt is 6 bits; cooldown is 8 bits.
  - frame_base is computed modulo 2^ADDR_W. The default parameters never wrap.
- Between frame_ticks, all state and outputs hold.

Test Plan:
- Reset then IDLE, kick_req pulse -> anim_active=1, frame_idx=0, frame_base=0 one cycle later. After 6 frame_ticks: frame_idx=1, frame_base=6144. After 12: frame_idx=2, frame_base=12288, hit_window=1. After 18: frame_idx=3, hit_window=0. After 24: done pulse, anim_active=0, busy=1.
- After the completion above, kick_req held high -> no restart during 10 cooldown ticks. On the 10th tick busy=0; the held kick_req restarts PLAY one cycle later.
- hit_stun asserted at frame_idx=2, tick_cnt=3 -> next cycle all outputs 0, aborted=1 for one cycle, done never pulses. A kick_req the next cycle starts immediately (no cooldown).
- kick_req and frame_tick in the same cycle in IDLE -> start; the first frame advance needs 6 further ticks. kick_req and hit_stun together in IDLE -> stays IDLE.
- Reset asserted mid-PLAY (frame_idx=1) -> next cycle everything is 0 and IDLE, no done/aborted pulse.
- COOLDOWN_TICKS=0, TICKS_PER_FRAME=1 -> frames advance on every tick; RECOVER lasts 1 cycle, then IDLE.
